// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA timing generator: counters, registered syncs, active flag, start strobes.
// Optional colour-bar outputs are built when VGA_SYNC_GEN_TEST_PATTERN_EN is defined.
module vga_sync_gen #(
  parameter int TOTAL_COLS       = 800,
  parameter int TOTAL_ROWS       = 525,
  parameter int ACTIVE_COLS      = 640,
  parameter int ACTIVE_ROWS      = 480,
  parameter int FRONT_PORCH_HORZ = 16,
  parameter int SYNC_WIDTH_HORZ  = 96,
  parameter int FRONT_PORCH_VERT = 10,
  parameter int SYNC_WIDTH_VERT  = 2,
  parameter int VIDEO_WIDTH      = 3
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Enable,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic [9:0] o_Col_Count,
  output logic [9:0] o_Row_Count,
  output logic       o_Active,
  output logic       o_Line_Start,
  output logic       o_Frame_Start
`ifdef VGA_SYNC_GEN_TEST_PATTERN_EN
  ,
  output logic [VIDEO_WIDTH-1:0] o_Red_Video,
  output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
  output logic [VIDEO_WIDTH-1:0] o_Blu_Video
`endif
);

  if (TOTAL_COLS > 1024 || TOTAL_ROWS > 1024) begin : g_bad_total
    $error("vga_sync_gen: TOTAL_COLS/TOTAL_ROWS must not exceed 1024");
  end
  if (ACTIVE_COLS + FRONT_PORCH_HORZ + SYNC_WIDTH_HORZ >= TOTAL_COLS ||
      ACTIVE_ROWS + FRONT_PORCH_VERT + SYNC_WIDTH_VERT >= TOTAL_ROWS) begin : g_bad_porch
    $error("vga_sync_gen: back porch must be at least one on each axis");
  end
  if (VIDEO_WIDTH < 1) begin : g_bad_video
    $error("vga_sync_gen: VIDEO_WIDTH must be at least 1");
  end

  typedef enum logic [1:0] {H_ACTIVE, H_FRONT, H_SYNC, H_BACK} h_state_t;
  typedef enum logic [1:0] {V_ACTIVE, V_FRONT, V_SYNC, V_BACK} v_state_t;

  localparam logic [9:0] LP_COL_LAST = 10'(TOTAL_COLS - 1);
  localparam logic [9:0] LP_ROW_LAST = 10'(TOTAL_ROWS - 1);
  localparam logic [9:0] LP_H_FRONT  = 10'(ACTIVE_COLS);
  localparam logic [9:0] LP_H_SYNC   = 10'(ACTIVE_COLS + FRONT_PORCH_HORZ);
  localparam logic [9:0] LP_H_BACK   = 10'(ACTIVE_COLS + FRONT_PORCH_HORZ + SYNC_WIDTH_HORZ);
  localparam logic [9:0] LP_V_FRONT  = 10'(ACTIVE_ROWS);
  localparam logic [9:0] LP_V_SYNC   = 10'(ACTIVE_ROWS + FRONT_PORCH_VERT);
  localparam logic [9:0] LP_V_BACK   = 10'(ACTIVE_ROWS + FRONT_PORCH_VERT + SYNC_WIDTH_VERT);

  logic [9:0] r_col, r_row;
  logic       r_hsync, r_vsync, r_active, r_line_start, r_frame_start;
  h_state_t   r_h_state, w_h_state;
  v_state_t   r_v_state, w_v_state;
  logic       w_col_wrap;
  logic [9:0] w_next_col, w_next_row;
  logic       w_next_active;

  assign w_col_wrap    = (r_col == LP_COL_LAST);
  assign w_next_col    = w_col_wrap ? 10'd0 : r_col + 10'd1;
  assign w_next_row    = !w_col_wrap ? r_row :
                         (r_row == LP_ROW_LAST) ? 10'd0 : r_row + 10'd1;
  assign w_next_active = (w_h_state == H_ACTIVE) && (w_v_state == V_ACTIVE);

  // State is decoded from the position the counters move to, so the
  // registered flags line up with the registered counts.
  always_comb begin
    w_h_state = r_h_state;
    w_v_state = r_v_state;
    if (i_Enable) begin
      if (w_next_col < LP_H_FRONT)     w_h_state = H_ACTIVE;
      else if (w_next_col < LP_H_SYNC) w_h_state = H_FRONT;
      else if (w_next_col < LP_H_BACK) w_h_state = H_SYNC;
      else                             w_h_state = H_BACK;
      if (w_col_wrap) begin
        if (w_next_row < LP_V_FRONT)     w_v_state = V_ACTIVE;
        else if (w_next_row < LP_V_SYNC) w_v_state = V_FRONT;
        else if (w_next_row < LP_V_BACK) w_v_state = V_SYNC;
        else                             w_v_state = V_BACK;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_col         <= LP_COL_LAST;
      r_row         <= LP_ROW_LAST;
      r_h_state     <= H_BACK;
      r_v_state     <= V_BACK;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_active      <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (i_Enable) begin
      r_col         <= w_next_col;
      r_row         <= w_next_row;
      r_h_state     <= w_h_state;
      r_v_state     <= w_v_state;
      r_hsync       <= (w_h_state != H_SYNC);
      r_vsync       <= (w_v_state != V_SYNC);
      r_active      <= w_next_active;
      r_line_start  <= (w_next_col == 10'd0);
      r_frame_start <= (w_next_col == 10'd0) && (w_next_row == 10'd0);
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  assign o_Col_Count   = r_col;
  assign o_Row_Count   = r_row;
  assign o_HSync       = r_hsync;
  assign o_VSync       = r_vsync;
  assign o_Active      = r_active;
  assign o_Line_Start  = r_line_start;
  assign o_Frame_Start = r_frame_start;

`ifdef VGA_SYNC_GEN_TEST_PATTERN_EN
  logic [VIDEO_WIDTH-1:0] r_red, r_grn, r_blu;
  logic [2:0]             w_bar;

  // Eight equal bars across the visible width.
  assign w_bar = 3'(({4'd0, w_next_col} * 14'd8) / 14'(ACTIVE_COLS));

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_red <= '0;
      r_grn <= '0;
      r_blu <= '0;
    end else if (i_Enable) begin
      r_red <= (w_next_active && w_bar[0]) ? '1 : '0;
      r_grn <= (w_next_active && w_bar[1]) ? '1 : '0;
      r_blu <= (w_next_active && w_bar[2]) ? '1 : '0;
    end
  end

  assign o_Red_Video = r_red;
  assign o_Grn_Video = r_grn;
  assign o_Blu_Video = r_blu;
`endif

endmodule
